// File: rtl/counter_mod.sv
// counter_mod: modulo-MODULUS up/down counter with synchronous clear, range-checked load,
// cascade terminal count and a registered wrap pulse. Define COUNTER_MOD_BCD_EN to add bcd_out.
module counter_mod #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 60
) (
  input  logic             clk,
  input  logic             a_clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             carry,
`ifdef COUNTER_MOD_BCD_EN
  output logic [7:0]       bcd_out,
`endif
  output logic             load_err
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $fatal(1, "counter_mod: WIDTH must be in 1..16");
  end

  if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "counter_mod: MODULUS must be in 2..2**WIDTH");
  end

  // One spare bit so MODULUS = 2**WIDTH is representable in the compares.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MOD_M1  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_q = '0;
  logic [WIDTH-1:0] count_d;
  logic             carry_q = 1'b0;
  logic             carry_d;
  logic             load_err_q = 1'b0;
  logic             load_err_d;

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   next_ext;
  logic             at_top;
  logic             at_zero;
  logic             load_ok;
  logic             unused_next_msb;

  assign cnt_ext  = {1'b0, count_q};
  assign load_ext = {1'b0, load_val};
  assign at_top   = (cnt_ext == MOD_M1);
  assign at_zero  = (cnt_ext == '0);
  assign load_ok  = (load_ext < MOD_EXT);

  // Cascade output: only a real count step at the terminal value may assert it.
  assign tc = en && !a_clr && !load && (up_dn ? at_top : at_zero);

  always_comb begin
    next_ext   = cnt_ext;
    load_err_d = 1'b0;
    carry_d    = tc;
    if (load) begin
      next_ext   = load_ok ? load_ext : '0;
      load_err_d = !load_ok;
    end else if (en) begin
      if (up_dn) begin
        next_ext = at_top ? '0 : (cnt_ext + ONE_EXT);
      end else begin
        next_ext = at_zero ? MOD_M1 : (cnt_ext - ONE_EXT);
      end
    end
  end

  // next_ext is always below MODULUS, so its top bit is always zero.
  assign count_d         = next_ext[WIDTH-1:0];
  assign unused_next_msb = next_ext[WIDTH];

  always_ff @(posedge clk) begin
    if (a_clr) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_out = count_q;
  assign carry     = carry_q;
  assign load_err  = load_err_q;

`ifdef COUNTER_MOD_BCD_EN
  if (MODULUS > 100) begin : g_bad_bcd_modulus
    $fatal(1, "counter_mod: MODULUS must be at most 100 with BCD output");
  end

  logic [6:0] bcd_bin;
  logic [7:0] bcd_d;
  logic [7:0] bcd_q = 8'h00;

  // Encoded from count_d so the digits land on the same edge as count_out.
  assign bcd_bin = 7'(count_d);

  always_comb begin
    bcd_d = {4'(bcd_bin / 7'd10), 4'(bcd_bin % 7'd10)};
  end

  always_ff @(posedge clk) begin
    if (a_clr) begin
      bcd_q <= 8'h00;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd_out = bcd_q;
`endif

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: three instances (8/60, 4/16, 1/2) share one stimulus set.
module tb_counter_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_clr    = 1'b0;
  logic       en       = 1'b0;
  logic       up_dn    = 1'b0;
  logic       load     = 1'b0;
  logic [7:0] load_val = 8'd0;

  logic [7:0] cnt60;
  logic       tc60, carry60, lerr60;
  logic [3:0] cnt16;
  logic       tc16, carry16, lerr16;
  logic [0:0] cnt2;
  logic       tc2, carry2, lerr2;
`ifdef COUNTER_MOD_BCD_EN
  logic [7:0] bcd60, bcd16, bcd2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  counter_mod #(.WIDTH(8), .MODULUS(60)) u60 (
    .clk(clk), .a_clr(a_clr), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count_out(cnt60), .tc(tc60), .carry(carry60),
`ifdef COUNTER_MOD_BCD_EN
    .bcd_out(bcd60),
`endif
    .load_err(lerr60)
  );

  counter_mod #(.WIDTH(4), .MODULUS(16)) u16 (
    .clk(clk), .a_clr(a_clr), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[3:0]), .count_out(cnt16), .tc(tc16), .carry(carry16),
`ifdef COUNTER_MOD_BCD_EN
    .bcd_out(bcd16),
`endif
    .load_err(lerr16)
  );

  counter_mod #(.WIDTH(1), .MODULUS(2)) u2 (
    .clk(clk), .a_clr(a_clr), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[0:0]), .count_out(cnt2), .tc(tc2), .carry(carry2),
`ifdef COUNTER_MOD_BCD_EN
    .bcd_out(bcd2),
`endif
    .load_err(lerr2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("init_count", 16'(cnt60), 16'd0);
    chk("init_carry", 16'(carry60), 16'd0);
    chk("init_lerr", 16'(lerr60), 16'd0);

    a_clr = 1'b1; en = 1'b1; up_dn = 1'b0; #1;
    chk("tc_forced_by_clr", 16'(tc60), 16'd0);
    tick;
    chk("clr_count", 16'(cnt60), 16'd0);
    chk("clr_carry", 16'(carry60), 16'd0);
    chk("clr_lerr", 16'(lerr60), 16'd0);
`ifdef COUNTER_MOD_BCD_EN
    chk("clr_bcd", 16'(bcd60), 16'h00);
`endif

    // full up sequence 0..59 then wrap
    a_clr = 1'b0; up_dn = 1'b1; #1;
    for (int i = 0; i < 60; i++) begin
      chk("up_count", 16'(cnt60), 16'(i));
      chk("up_tc", 16'(tc60), (i == 59) ? 16'd1 : 16'd0);
      chk("up_carry", 16'(carry60), 16'd0);
      tick;
    end
    chk("wrap_count", 16'(cnt60), 16'd0);
    chk("wrap_carry", 16'(carry60), 16'd1);
    tick;
    chk("post_wrap_count", 16'(cnt60), 16'd1);
    chk("post_wrap_carry", 16'(carry60), 16'd0);

    // down wrap with same-edge direction change
    up_dn = 1'b0; #1;
    chk("down_tc_at1", 16'(tc60), 16'd0);
    tick;
    chk("dir_change_count", 16'(cnt60), 16'd0);
    chk("down_tc_at0", 16'(tc60), 16'd1);
    tick;
    chk("down_wrap_count", 16'(cnt60), 16'd59);
    chk("down_wrap_carry", 16'(carry60), 16'd1);
    chk("down_tc_at59", 16'(tc60), 16'd0);
    tick;
    chk("down_step_count", 16'(cnt60), 16'd58);
    chk("down_carry_clear", 16'(carry60), 16'd0);

    // loads
    en = 1'b0; load = 1'b1; load_val = 8'd42;
    tick;
    chk("load42_count", 16'(cnt60), 16'd42);
    chk("load42_lerr", 16'(lerr60), 16'd0);
    chk("load42_carry", 16'(carry60), 16'd0);
    load_val = 8'd75;
    tick;
    chk("load75_count", 16'(cnt60), 16'd0);
    chk("load75_lerr", 16'(lerr60), 16'd1);
    load = 1'b0;
    tick;
    chk("hold_count", 16'(cnt60), 16'd0);
    chk("lerr_one_cycle", 16'(lerr60), 16'd0);
    load = 1'b1; load_val = 8'd59;
    tick;
    chk("load59_count", 16'(cnt60), 16'd59);
    chk("load59_lerr", 16'(lerr60), 16'd0);
    load_val = 8'd60;
    tick;
    chk("load60_count", 16'(cnt60), 16'd0);
    chk("load60_lerr", 16'(lerr60), 16'd1);
    en = 1'b1; up_dn = 1'b0; load_val = 8'd10; #1;
    chk("tc_forced_by_load", 16'(tc60), 16'd0);
    tick;
    chk("load_en_count", 16'(cnt60), 16'd10);
    chk("load_en_lerr", 16'(lerr60), 16'd0);
    chk("load_en_carry", 16'(carry60), 16'd0);
    load = 1'b0; up_dn = 1'b1;
    tick;
    chk("step_after_load", 16'(cnt60), 16'd11);
    en = 1'b0;
    tick;
    chk("hold_en_low", 16'(cnt60), 16'd11);

    // clear mid-count overrides load and en
    load = 1'b1; load_val = 8'd30;
    tick;
    chk("load30_count", 16'(cnt60), 16'd30);
    a_clr = 1'b1; load_val = 8'd75; en = 1'b1;
    tick;
    chk("midclr_count", 16'(cnt60), 16'd0);
    chk("midclr_carry", 16'(carry60), 16'd0);
    chk("midclr_lerr", 16'(lerr60), 16'd0);
    a_clr = 1'b0; load = 1'b0;
    tick;
    chk("resume_1", 16'(cnt60), 16'd1);
    tick;
    chk("resume_2", 16'(cnt60), 16'd2);

    // tc needs en at the terminal value
    en = 1'b0; load = 1'b1; load_val = 8'd59;
    tick;
    load = 1'b0; #1;
    chk("tc_en_low", 16'(tc60), 16'd0);
    en = 1'b1; #1;
    chk("tc_en_high", 16'(tc60), 16'd1);
    tick;
    chk("wrap2_count", 16'(cnt60), 16'd0);
    chk("wrap2_carry", 16'(carry60), 16'd1);

`ifdef COUNTER_MOD_BCD_EN
    en = 1'b0; load = 1'b1; load_val = 8'd47;
    tick;
    chk("bcd_47", 16'(bcd60), 16'h47);
    load_val = 8'd59;
    tick;
    chk("bcd_59", 16'(bcd60), 16'h59);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick;
    chk("bcd_wrap", 16'(bcd60), 16'h00);
`endif

    // WIDTH=4, MODULUS=16 full-range wraps
    a_clr = 1'b1; load = 1'b0; en = 1'b0;
    tick;
    chk("w4_clr", 16'(cnt16), 16'd0);
    a_clr = 1'b0; load = 1'b1; load_val = 8'd14; en = 1'b1; up_dn = 1'b1;
    tick;
    chk("w4_load14", 16'(cnt16), 16'd14);
    load = 1'b0;
    tick;
    chk("w4_up15", 16'(cnt16), 16'd15);
    chk("w4_tc15", 16'(tc16), 16'd1);
    tick;
    chk("w4_wrap_up", 16'(cnt16), 16'd0);
    chk("w4_carry_up", 16'(carry16), 16'd1);
    tick;
    chk("w4_up1", 16'(cnt16), 16'd1);
    chk("w4_carry_up_clear", 16'(carry16), 16'd0);
    up_dn = 1'b0;
    tick;
    chk("w4_down0", 16'(cnt16), 16'd0);
    chk("w4_tc0", 16'(tc16), 16'd1);
    tick;
    chk("w4_wrap_down", 16'(cnt16), 16'd15);
    chk("w4_carry_down", 16'(carry16), 16'd1);
    tick;
    chk("w4_down14", 16'(cnt16), 16'd14);
    chk("w4_carry_down_clear", 16'(carry16), 16'd0);
    chk("w4_lerr", 16'(lerr16), 16'd0);

    // MODULUS=2: a carry on every wrap
    a_clr = 1'b1; en = 1'b0;
    tick;
    chk("m2_clr", 16'(cnt2), 16'd0);
    a_clr = 1'b0; en = 1'b1; up_dn = 1'b1; #1;
    chk("m2_tc_start", 16'(tc2), 16'd0);
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk("m2_up_count", 16'(cnt2), 16'(k % 2));
      chk("m2_up_carry", 16'(carry2), (k % 2 == 0) ? 16'd1 : 16'd0);
      chk("m2_up_tc", 16'(tc2), 16'(k % 2));
    end
    up_dn = 1'b0; #1;
    chk("m2_down_tc_start", 16'(tc2), 16'd1);
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk("m2_down_count", 16'(cnt2), 16'(k % 2));
      chk("m2_down_carry", 16'(carry2), 16'(k % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_mod.md
COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 Parameter WIDTH, default 8, counter register width in bits; legal range 1..16.
REQ-002 Parameter MODULUS, default 60, count sequence length; legal range 2..2**WIDTH.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 a_clr  input  1  reset, synchronous, active-high, sampled on the rising edge of clk.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 up_dn  input  1  direction; 1 = count up, 0 = count down.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  WIDTH  value captured when load is high.
REQ-009 count_out  output  WIDTH  registered current count.
REQ-010 tc  output  1  combinational terminal count, for cascading into the next stage's en.
REQ-011 carry  output  1  registered one-cycle wrap pulse.
REQ-012 load_err  output  1  registered one-cycle pulse flagging an out-of-range load.

Function
REQ-013 Priority per edge: a_clr over load over en; with none of these active, count_out shall hold.
REQ-014 en=1, up_dn=1: count_out shall step to count_out+1, or to 0 when count_out = MODULUS-1.
REQ-015 en=1, up_dn=0: count_out shall step to count_out-1, or to MODULUS-1 when count_out = 0.
REQ-016 count_out shall never hold a value >= MODULUS after any edge.
REQ-017 Arithmetic shall be done at WIDTH+1 bits internally; MODULUS = 2**WIDTH shall wrap correctly with no overflow artefacts.
REQ-018 tc shall be high when en=1 and count_out is at the terminal value: MODULUS-1 when up_dn=1, 0 when up_dn=0.
REQ-019 tc shall be forced low while a_clr or load is high.
REQ-020 carry shall be high for exactly the one cycle after an edge where tc was high; otherwise low.
REQ-021 Consecutive wraps (MODULUS=2, en held high) shall produce carry on every wrap with no pulse merging.
REQ-022 load with load_val < MODULUS: count_out = load_val on the next edge; carry low; load_err low.
REQ-023 load with load_val >= MODULUS: count_out = 0 on the next edge; load_err high for one cycle.
REQ-024 load and en high together: the load takes effect and no count step occurs that edge.
REQ-025 A direction change shall take effect on the same edge it is sampled; there shall be no dead cycle.
REQ-026 Latency: the control inputs affect count_out exactly one edge later.

Reset
REQ-027 a_clr high at an edge: count_out=0, carry=0, load_err=0; BCD outputs, if present, shall read 0.
REQ-028 a_clr mid-count shall override load and en that cycle; counting shall resume from 0 on the first edge after a_clr goes low.
REQ-029 Before the first reset, count_out shall initialise to 0 in simulation.

Configuration
REQ-030 Macro COUNTER_MOD_BCD_EN, when defined, shall add output bcd_out [7:0]: tens digit in [7:4], units digit in [3:0].
REQ-031 bcd_out shall be registered and updated on the same edge as count_out, with zero added latency.
REQ-032 With COUNTER_MOD_BCD_EN, MODULUS shall be at most 100; a larger value shall be a fatal elaboration error.
REQ-033 Without COUNTER_MOD_BCD_EN, the bcd_out port and its logic shall be absent, with no other behaviour change.

Verification
REQ-034 Up wrap, WIDTH=8, MODULUS=60, en=1, up_dn=1 from reset: count_out 0..59 then 0; tc high at 59; carry high one cycle when count_out=0.
REQ-035 Down wrap, count_out=0, up_dn=0, en=1: next count_out=59; carry pulses once; tc high at 0.
REQ-036 Loads: load_val=42 -> count_out=42, load_err=0; load_val=75 -> count_out=0, load_err=1 for one cycle; load and en together -> loaded value, no step.
REQ-037 Reset mid-count, count_out=30, a_clr=1 with load=1 and en=1: count_out=0, carry=0; en then gives 1, 2, ...
REQ-038 Full range, WIDTH=4, MODULUS=16, up then down: wraps 15->0 and 0->15, each with a single carry pulse.
REQ-039 COUNTER_MOD_BCD_EN defined, MODULUS=60: count_out=47 -> bcd_out=8'h47; wrap 59->0 -> bcd_out=8'h00.
